apb_cfg_slave: RTL and testbench
================================

# apb_cfg_slave

APB3 slave front-end that sits directly upstream of the configuration memory and turns APB transfers into single-cycle memory write and read strobes. It decodes and checks the address, sequences the APB handshake with wait states for reads, and returns read data and error status to the APB master. The memory's system-side read port is not touched by this block.

## Interface
- `ADDR_W`, default 16: APB address width in bits; byte addressing.
- `DATA_W`, default 32: data width.
- `DEPTH`, default 256: number of memory words.
- `LOCK_ADDR`, default 16'hFFFC: address of the lock register (used only with the macro).

- `pclk` input 1: the single clock. All logic is clocked on the rising edge.
- `prst` input 1: synchronous, active-high reset.
- `psel` input 1: APB select.
- `penable` input 1: APB enable (access phase).
- `pwrite` input 1: 1 = write, 0 = read.
- `paddr` input ADDR_W: APB byte address.
- `pwdata` input DATA_W: APB write data.
- `prdata` output DATA_W: APB read data.
- `pready` output 1: transfer-complete strobe.
- `pslverr` output 1: error flag; valid only while `pready`=1.
- `mem_addr` output ADDR_W: word index, equal to `{2'b00, paddr[ADDR_W-1:2]}`.
- `mem_wdata` output DATA_W: write data to the memory.
- `mem_we` output 1: memory write strobe, one cycle wide.
- `mem_re` output 1: memory read strobe, one cycle wide.
- `mem_rdata` input DATA_W: memory read data, valid the cycle after `mem_re`.

## Operation
- **Registered outputs.** All outputs are registered.
- **Reset.** After `prst`, all outputs are 0 and the state is IDLE.
- **States.** IDLE, WR_ACK, RD_REQ, RD_WAIT, RD_ACK, ERR_ACK.
- **IDLE.** A setup phase (`psel`=1, `penable`=0) latches `paddr`, `pwdata` and `pwrite`, then decodes the transfer:
  - The address is valid when `paddr[1:0]`==0 and `paddr[ADDR_W-1:2]` < `DEPTH`.
  - Invalid address: go to ERR_ACK.
  - Valid write: go to WR_ACK.
  - Valid read: go to RD_REQ.
- **WR_ACK** (one cycle): `mem_we`=1, `mem_addr` and `mem_wdata` driven, `pready`=1, `pslverr`=0. Then go to IDLE.
- **RD_REQ** (one cycle): `mem_re`=1, `pready`=0. Then go to RD_WAIT.
- **RD_WAIT** (one cycle): capture `mem_rdata` into `prdata`; `pready`=0. Then go to RD_ACK.
- **RD_ACK** (one cycle): `pready`=1, `prdata` valid, `pslverr`=0. Then go to IDLE.
- **ERR_ACK** (one cycle): `pready`=1, `pslverr`=1, `prdata`=0, no memory strobe. Then go to IDLE.
- **`prdata` outside RD_ACK.** `prdata` is 0 whenever `pready`=0, and in every non-read ack.
- **`psel` dropped in RD_REQ or RD_WAIT.** This is a master protocol violation. Go to IDLE on the next edge, with no `pready` and no further strobes. A `mem_re` already issued is not retracted.
- **`penable`=1 without a preceding setup while in IDLE.** Ignored.
- **Address boundaries.**
  - `paddr` = 4×(`DEPTH`−1) is accepted.
  - `paddr` = 4×`DEPTH` is an error.
  - No wrap-around of the address.
- **Reset mid-transfer.** Go to IDLE. Outputs are 0 on the next cycle, and a pending ack is lost.

## Timing
- Cycle T0 is the setup phase. The access phase starts at T1.
- Write: `mem_we` and `pready` at T1. Zero wait states; completes at the end of T1.
- Read: `mem_re` at T1, `mem_rdata` at T2, `pready` with `prdata` at T3. Two wait states.
- Error: `pready` and `pslverr` at T1.
- Back-to-back transfers: the next setup may arrive in the cycle after the ack. Minimum transfer spacing is 2 cycles for writes and 4 for reads.

## Configuration
- `APB_CFG_LOCK_EN` defined:
  - A 1-bit lock register is decoded at `LOCK_ADDR`; this decode takes precedence over range checking.
  - A write to it with `pwdata[0]`=1 sets the lock. The lock is sticky until `prst`; writing 0 has no effect. The lock-register write itself completes like WR_ACK, but without `mem_we`.
  - A read of it completes at T1 with `prdata`={0…, lock}, `pslverr`=0 and no `mem_re`.
  - While locked, any memory write goes to ERR_ACK with no `mem_we`. Reads are unaffected.
- `APB_CFG_LOCK_EN` undefined:
  - No lock register exists. `LOCK_ADDR` is decoded as an ordinary address and, at the default value, returns an error.

## Test plan
- **Reset.** Assert `prst` for 2 cycles → all outputs 0; first transfer after release completes normally.
- **Write then read.** Write 0xDEADBEEF to 0x0010 → `mem_we`=1 at T1 with `mem_addr`=4 and `pready`=1. Then read 0x0010 → `mem_re` at T1; `pready`=1 and `prdata`=0xDEADBEEF at T3.
- **Address errors.**
  - Read 0x0402 (unaligned) → `pslverr`=1 at T1, no strobes.
  - Write 0x0400 (`DEPTH`=256) → `pslverr`=1 at T1, no strobes.
  - 0x03FC → accepted.
- **Back-to-back and mid-read reset.** Writes to 0x0, 0x4 and 0x8 on consecutive 2-cycle transfers → three `mem_we` pulses with correct `mem_addr`. Then start a read and assert `prst` at T2 → no `pready`, outputs 0.
- **Lock (`APB_CFG_LOCK_EN`).** Write 1 to 0xFFFC, then write 0x5 to 0x0 → `pslverr`=1, no `mem_we`. Read 0xFFFC → `prdata`=1 at T1.

Source files
------------

// File: rtl/apb_cfg_slave.sv
// APB3 slave front-end for the configuration memory: decode, wait states, error status.
// Optional lock register is built when APB_CFG_LOCK_EN is defined.
module apb_cfg_slave #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter logic [ADDR_W-1:0] LOCK_ADDR = 'hFFFC
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, WR_ACK, RD_REQ, RD_WAIT, RD_ACK, ERR_ACK
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t state, state_n;
  logic [DATA_W-1:0] prdata_n, mem_wdata_n;
  logic [ADDR_W-1:0] mem_addr_n, word;
  logic pready_n, pslverr_n, mem_we_n, mem_re_n;
  logic setup, addr_ok, lock_hit, lock_q;

  assign setup   = psel && !penable;
  assign word    = {2'b00, paddr[ADDR_W-1:2]};
  assign addr_ok = (paddr[1:0] == 2'b00) && ({1'b0, word} < DEPTH_L);

`ifdef APB_CFG_LOCK_EN
  assign lock_hit = (paddr == LOCK_ADDR);

  // sticky until reset; only a 1 in bit 0 has any effect
  always_ff @(posedge pclk) begin
    if (prst)
      lock_q <= 1'b0;
    else if (state == IDLE && setup && lock_hit && pwrite && pwdata[0])
      lock_q <= 1'b1;
  end
`else
  assign lock_hit = 1'b0;
  assign lock_q   = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    prdata_n    = '0;
    pready_n    = 1'b0;
    pslverr_n   = 1'b0;
    mem_addr_n  = '0;
    mem_wdata_n = '0;
    mem_we_n    = 1'b0;
    mem_re_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (setup) begin
          if (lock_hit) begin
            pready_n = 1'b1;
            if (pwrite) begin
              state_n = WR_ACK;
            end else begin
              state_n  = RD_ACK;
              prdata_n = DATA_W'(lock_q);
            end
          end else if (!addr_ok || (pwrite && lock_q)) begin
            state_n   = ERR_ACK;
            pready_n  = 1'b1;
            pslverr_n = 1'b1;
          end else if (pwrite) begin
            state_n     = WR_ACK;
            pready_n    = 1'b1;
            mem_we_n    = 1'b1;
            mem_addr_n  = word;
            mem_wdata_n = pwdata;
          end else begin
            state_n    = RD_REQ;
            mem_re_n   = 1'b1;
            mem_addr_n = word;
          end
        end
      end
      RD_REQ: state_n = psel ? RD_WAIT : IDLE;
      RD_WAIT: begin
        if (psel) begin
          state_n  = RD_ACK;
          pready_n = 1'b1;
          prdata_n = mem_rdata;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state     <= IDLE;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      state     <= state_n;
      prdata    <= prdata_n;
      pready    <= pready_n;
      pslverr   <= pslverr_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_we    <= mem_we_n;
      mem_re    <= mem_re_n;
    end
  end

endmodule

// File: tb/tb_apb_cfg_slave.sv
// Directed bench for apb_cfg_slave with a small behavioural memory.
// Lock steps run only when APB_CFG_LOCK_EN is defined.
module tb_apb_cfg_slave;

  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [15:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata = '0;

  int n_assert = 0;
  int n_fail = 0;

  logic [31:0] mem [0:255];

  apb_cfg_slave dut (
    .pclk(pclk), .prst(prst), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setup(input logic w, input logic [15:0] a,
                       input logic [31:0] d);
    psel = 1'b1;
    penable = 1'b0;
    pwrite = w;
    paddr = a;
    pwdata = d;
  endtask

  task automatic access();
    penable = 1'b1;
  endtask

  task automatic idle();
    psel = 1'b0;
    penable = 1'b0;
  endtask

  function automatic logic [63:0] all_out();
    return {32'(prdata | mem_wdata), 16'(mem_addr),
            12'h0, pready, pslverr, mem_we, mem_re};
  endfunction

  initial begin
    // reset held for two cycles
    repeat (2) step();
    chk("rst_flags", {pready, pslverr, mem_we, mem_re}, 4'b0000);
    chk("rst_data", {prdata, mem_wdata}, 64'h0);
    chk("rst_addr", mem_addr, 16'h0);
    prst = 1'b0;

    // write 0xDEADBEEF to 0x0010
    setup(1'b1, 16'h0010, 32'hDEADBEEF);
    step();
    chk("wr_flags", {pready, pslverr, mem_we, mem_re}, 4'b1010);
    chk("wr_addr", mem_addr, 16'h0004);
    chk("wr_data", mem_wdata, 32'hDEADBEEF);
    chk("wr_prdata", prdata, 32'h0);
    access();
    step();
    idle();
    chk("wr_t2", {pready, mem_we}, 2'b00);

    // read back from 0x0010
    setup(1'b0, 16'h0010, 32'h0);
    step();
    chk("rd_t1", {pready, mem_we, mem_re}, 3'b001);
    chk("rd_addr", mem_addr, 16'h0004);
    access();
    step();
    chk("rd_t2", {pready, mem_re}, 2'b00);
    chk("rd_t2_prdata", prdata, 32'h0);
    step();
    chk("rd_t3", {pready, pslverr}, 2'b10);
    chk("rd_t3_prdata", prdata, 32'hDEADBEEF);
    step();
    idle();
    chk("rd_t4", {pready, prdata}, 33'h0);

    // unaligned read
    setup(1'b0, 16'h0402, 32'h0);
    step();
    chk("unal_flags", {pready, pslverr, mem_we, mem_re}, 4'b1100);
    chk("unal_prdata", prdata, 32'h0);
    access();
    step();
    idle();
    chk("unal_t2", {pready, pslverr}, 2'b00);

    // write just past the end
    setup(1'b1, 16'h0400, 32'h1);
    step();
    chk("oor_flags", {pready, pslverr, mem_we, mem_re}, 4'b1100);
    access();
    step();
    idle();

    // last word is accepted
    setup(1'b1, 16'h03FC, 32'h12345678);
    step();
    chk("last_wr", {pready, pslverr, mem_we, mem_re}, 4'b1010);
    chk("last_addr", mem_addr, 16'h00FF);
    access();
    step();
    setup(1'b0, 16'h03FC, 32'h0);
    step();
    chk("last_rd_t1", {pready, mem_re}, 2'b01);
    access();
    step();
    step();
    chk("last_rd_t3", {pready, pslverr, prdata}, {2'b10, 32'h12345678});
    step();
    idle();

    // back-to-back writes, two cycles apart
    for (int i = 0; i < 3; i++) begin
      setup(1'b1, 16'(4 * i), 32'hA0 + 32'(i));
      step();
      chk("b2b_we", {pready, mem_we}, 2'b11);
      chk("b2b_addr", mem_addr, 16'(i));
      access();
      step();
      chk("b2b_gap", mem_we, 1'b0);
    end
    idle();
    chk("b2b_mem", {mem[0][7:0], mem[1][7:0], mem[2][7:0]}, 24'hA0A1A2);

    // reset at T2 of a read
    setup(1'b0, 16'h0000, 32'h0);
    step();
    chk("mid_rst_t1", mem_re, 1'b1);
    access();
    step();
    prst = 1'b1;
    step();
    chk("mid_rst_out", all_out(), 64'h0);
    prst = 1'b0;
    idle();
    step();
    chk("mid_rst_after", all_out(), 64'h0);

    // psel dropped during RD_REQ
    setup(1'b0, 16'h0004, 32'h0);
    step();
    chk("drop_t1", mem_re, 1'b1);
    idle();
    step();
    chk("drop_t2", all_out(), 64'h0);
    step();
    chk("drop_t3", all_out(), 64'h0);

    // penable without a setup phase is ignored
    psel = 1'b1;
    penable = 1'b1;
    pwrite = 1'b1;
    paddr = 16'h0008;
    pwdata = 32'hFF;
    step();
    chk("noset", {pready, mem_we, mem_re}, 3'b000);
    idle();
    step();

`ifdef APB_CFG_LOCK_EN
    setup(1'b1, 16'hFFFC, 32'h1);
    step();
    chk("lock_wr", {pready, pslverr, mem_we, mem_re}, 4'b1000);
    access();
    step();
    setup(1'b1, 16'h0000, 32'h5);
    step();
    chk("locked_wr", {pready, pslverr, mem_we, mem_re}, 4'b1100);
    access();
    step();
    setup(1'b0, 16'hFFFC, 32'h0);
    step();
    chk("lock_rd", {pready, pslverr, mem_re, prdata}, {3'b100, 32'h1});
    access();
    step();
    setup(1'b0, 16'h0000, 32'h0);
    step();
    access();
    step();
    step();
    chk("locked_rd", {pready, prdata}, {1'b1, 32'hA0});
    step();
    idle();
`else
    setup(1'b1, 16'hFFFC, 32'h1);
    step();
    chk("nolock_err", {pready, pslverr, mem_we, mem_re}, 4'b1100);
    access();
    step();
    idle();
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
